// File: rtl/midi_transmitter_pkg.sv
// MIDI OUT shared definitions: channel-voice nibbles, note bundle,
// UART timing and the byte FSM state encoding.
package midi_transmitter_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned MIDI_BAUD = 31_250;
  localparam int unsigned CFG_CLOCKS_PER_BIT =
    CLK_FREQ_HZ / MIDI_BAUD;

  localparam int unsigned FRAME_BITS = 10;

  localparam logic [3:0] STATUS_NOTE_ON = 4'h9;
  localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;

  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_status_e;

  typedef struct packed {
    note_status_e status;
    logic [7:0]   note_number;
    logic [7:0]   velocity;
  } note_change_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STATUS,
    ST_SEND_DATA1,
    ST_SEND_DATA2,
    ST_DRAIN
  } tx_state_e;

  function automatic logic [7:0] status_byte(
    input note_status_e s,
    input logic [3:0]   ch
  );
    logic [3:0] hi;
    hi = (s == NOTE_ON) ? STATUS_NOTE_ON
                        : STATUS_NOTE_OFF;
    return {hi, ch};
  endfunction

  // Data bytes always carry a clear MSB.
  function automatic logic [7:0] data_byte(
    input logic [7:0] v
  );
    return v & 8'h7F;
  endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// MIDI OUT byte serialiser: start, d0..d7, stop at a fixed
// number of clocks per bit, with back-to-back reload support.
module midi_uart_tx
  import midi_transmitter_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = CFG_CLOCKS_PER_BIT
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       done,
  output logic       idle
);

  localparam int unsigned BW = $clog2(CLOCKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_DONE =
    BW'(CLOCKS_PER_BIT - 2);

  localparam logic [3:0] BIT_STOP =
    4'(FRAME_BITS - 1);
  localparam logic [3:0] BIT_D7 =
    4'(FRAME_BITS - 2);

  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_active;
  logic          r_tx;

  logic w_bit_end;
  logic w_frame_end;
  logic w_start;

  assign w_bit_end = r_active
                  && (r_baud == BAUD_LAST);
  assign w_frame_end = w_bit_end
                    && (r_bit == BIT_STOP);

  // A load is taken when idle, or exactly at the end
  // of the current stop bit so frames abut.
  assign w_start = load
                && (!r_active || w_frame_end);

  // done fires one cycle before the stop bit ends so a
  // registered load from the FSM lands on the boundary.
  assign done = r_active
             && (r_bit == BIT_STOP)
             && (r_baud == BAUD_DONE);

  assign idle = !r_active;
  assign tx = r_tx;

  // Bit/baud counters and the shifting line driver.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_active <= 1'b0;
      r_tx     <= 1'b1;
    end else if (w_start) begin
      r_active <= 1'b1;
      r_shift  <= data;
      r_bit    <= '0;
      r_baud   <= '0;
      r_tx     <= 1'b0;
    end else if (w_frame_end) begin
      r_active <= 1'b0;
      r_bit    <= '0;
      r_baud   <= '0;
      r_tx     <= 1'b1;
    end else if (w_bit_end) begin
      r_baud <= '0;
      r_bit  <= r_bit + 4'd1;
      if (r_bit == BIT_D7) begin
        r_tx <= 1'b1;
      end else begin
        r_tx    <= r_shift[0];
        r_shift <= {1'b0, r_shift[7:1]};
      end
    end else if (r_active) begin
      r_baud <= r_baud + 1'b1;
    end
  end

endmodule

// File: rtl/midi_transmitter.sv
// MIDI OUT top: accepts one note change per handshake and sends
// it as a channel-voice message, optionally with running status.
module midi_transmitter
  import midi_transmitter_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = CFG_CLOCKS_PER_BIT,
  parameter bit          RUNNING_STATUS = 1'b1
) (
  input  logic         clock_50_000_000,
  input  logic         reset_l,
  input  logic [3:0]   channel,
  input  note_change_t note,
  input  logic         note_valid,
  output logic         note_ready,
  output logic         midi_tx,
  output logic         busy
);

  tx_state_e  r_state;
  logic [7:0] r_byte;
  logic [7:0] r_data1;
  logic [7:0] r_data2;
  logic       r_load;
  logic [7:0] r_last_status;
  logic       r_last_vld;
  logic       r_ready;
  logic       r_busy;

  logic [7:0] w_status;
  logic [7:0] w_data1;
  logic [7:0] w_data2;
  logic       w_skip;
  logic       w_accept;
  logic       w_done;
  logic       w_uart_idle;
  logic       w_tx;

  assign w_status = status_byte(note.status, channel);
  assign w_data1  = data_byte(note.note_number);
  assign w_data2  = data_byte(note.velocity);

  // Channel is part of the compare, so a channel
  // change always re-sends the status byte.
  assign w_skip = RUNNING_STATUS
               && r_last_vld
               && (r_last_status == w_status);

  assign w_accept = note_valid
                 && r_ready
                 && w_uart_idle;

  assign note_ready = r_ready;
  assign busy       = r_busy;
  assign midi_tx    = w_tx;

  // Byte sequencer: status (unless skipped), data1, data2.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_state       <= ST_IDLE;
      r_byte        <= '0;
      r_data1       <= '0;
      r_data2       <= '0;
      r_load        <= 1'b0;
      r_last_status <= '0;
      r_last_vld    <= 1'b0;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_load <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data1 <= w_data1;
            r_data2 <= w_data2;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_load  <= 1'b1;
            if (w_skip) begin
              r_byte  <= w_data1;
              r_state <= ST_SEND_DATA1;
            end else begin
              r_byte        <= w_status;
              r_last_status <= w_status;
              r_last_vld    <= 1'b1;
              r_state       <= ST_SEND_STATUS;
            end
          end
        end
        ST_SEND_STATUS: begin
          if (w_done) begin
            r_byte  <= r_data1;
            r_load  <= 1'b1;
            r_state <= ST_SEND_DATA1;
          end
        end
        ST_SEND_DATA1: begin
          if (w_done) begin
            r_byte  <= r_data2;
            r_load  <= 1'b1;
            r_state <= ST_SEND_DATA2;
          end
        end
        ST_SEND_DATA2: begin
          if (w_done) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  midi_uart_tx #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_uart (
    .clock_50_000_000(clock_50_000_000),
    .reset_l         (reset_l),
    .data            (r_byte),
    .load            (r_load),
    .tx              (w_tx),
    .done            (w_done),
    .idle            (w_uart_idle)
  );

endmodule

// File: tb/tb_midi_transmitter.sv
// Directed plus random bench for midi_transmitter: line decode,
// bit timing, handshake timing and running-status behaviour.
module tb_midi_transmitter;
  import midi_transmitter_pkg::*;

  localparam int CPB  = 16;
  localparam int MAXS = 30 * CPB + 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   ch = 4'h0;
  note_change_t nt = '0;
  logic         vld = 1'b0;
  logic         rdy;
  logic         tx;
  logic         bsy;

  int checks = 0;
  int errors = 0;

  logic [7:0] last_st = 8'h00;
  bit         last_vld = 1'b0;
  logic [7:0] exp_q[$];

  logic tx_s [0:MAXS];
  logic rdy_s[0:MAXS];
  logic bsy_s[0:MAXS];

  always #10 clk = ~clk;

  midi_transmitter #(
    .CLOCKS_PER_BIT(CPB),
    .RUNNING_STATUS(1'b1)
  ) dut (
    .clock_50_000_000(clk),
    .reset_l         (rst_n),
    .channel         (ch),
    .note            (nt),
    .note_valid      (vld),
    .note_ready      (rdy),
    .midi_tx         (tx),
    .busy            (bsy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference: list of bytes a message must put on the line.
  function automatic void model(input logic [3:0] c,
                                input bit on,
                                input logic [7:0] n,
                                input logic [7:0] v);
    logic [7:0] s;
    s = (on ? 8'h90 : 8'h80) | {4'h0, c};
    exp_q.delete();
    if (!(last_vld && last_st == s)) begin
      exp_q.push_back(s);
      last_st  = s;
      last_vld = 1'b1;
    end
    exp_q.push_back(n & 8'h7F);
    exp_q.push_back(v & 8'h7F);
  endfunction

  // Called on a negedge; returns on the negedge after accept.
  task automatic issue(input logic [3:0] c, input bit on,
                       input logic [7:0] n, input logic [7:0] v,
                       input string tag);
    bit   ok;
    logic r;
    ok = 1'b0;
    ch = c;
    nt.status      = on ? NOTE_ON : NOTE_OFF;
    nt.note_number = n;
    nt.velocity    = v;
    vld = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = rdy;
      @(posedge clk);
      if (r === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check({tag, " accept"}, 32'(ok), 32'd1);
    if (ok) model(c, on, n, v);
  endtask

  // Record the whole message from sample 0 and check it.
  task automatic capture(input string tag);
    int         nb;
    int         rr;
    int         glitch;
    int         bbad;
    int         first;
    int         s;
    logic       e;
    logic [7:0] dec;
    nb = exp_q.size();
    rr = 10 * nb * CPB + 1;
    glitch = 0;
    bbad = 0;
    first = -1;
    for (int k = 0; k <= rr; k++) begin
      tx_s[k]  = tx;
      rdy_s[k] = rdy;
      bsy_s[k] = bsy;
      if (k < rr) @(negedge clk);
    end
    if (tx_s[0] !== 1'b1) glitch++;
    if (tx_s[rr] !== 1'b1) glitch++;
    for (int f = 0; f < nb; f++) begin
      dec = 8'h00;
      for (int b = 0; b < 10; b++) begin
        if (b == 0) e = 1'b0;
        else if (b == 9) e = 1'b1;
        else e = exp_q[f][b-1];
        for (int j = 0; j < CPB; j++) begin
          s = 1 + (f * 10 + b) * CPB + j;
          if (tx_s[s] !== e) glitch++;
        end
        if (b >= 1 && b <= 8)
          dec[b-1] = tx_s[1 + (f * 10 + b) * CPB + CPB / 2];
      end
      check($sformatf("%s byte%0d", tag, f),
            32'(dec), 32'(exp_q[f]));
    end
    for (int k = 0; k <= rr; k++) begin
      if (first < 0 && rdy_s[k] === 1'b1) first = k;
      if (bsy_s[k] !== !rdy_s[k]) bbad++;
    end
    check({tag, " bit timing"}, 32'(glitch), 32'd0);
    check({tag, " ready return"}, 32'(first), 32'(rr));
    check({tag, " busy"}, 32'(bbad), 32'd0);
  endtask

  initial begin
    int bad;
    logic [3:0] rc;
    bit         ron;
    logic [7:0] rn;
    logic [7:0] rv;

    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset ready", 32'(rdy), 32'd1);
    check("reset busy", 32'(bsy), 32'd0);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || rdy !== 1'b1 || bsy !== 1'b0)
        bad++;
    end
    check("idle", 32'(bad), 32'd0);

    issue(4'h0, 1'b1, 8'd60, 8'd100, "on60");
    vld = 1'b0;
    capture("on60");

    issue(4'h0, 1'b1, 8'd62, 8'd64, "rs62");
    vld = 1'b0;
    check("rs62 len", 32'(exp_q.size()), 32'd2);
    capture("rs62");

    issue(4'h0, 1'b0, 8'd62, 8'd64, "off62");
    vld = 1'b0;
    capture("off62");

    issue(4'h0, 1'b1, 8'd70, 8'd90, "holdA");
    nt.note_number = 8'd71;
    nt.velocity    = 8'd20;
    capture("holdA");
    issue(4'h0, 1'b1, 8'd71, 8'd20, "holdB");
    vld = 1'b0;
    capture("holdB");
    bad = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || rdy !== 1'b1) bad++;
    end
    check("no dup", 32'(bad), 32'd0);

    issue(4'hF, 1'b1, 8'hFF, 8'hFF, "max");
    vld = 1'b0;
    capture("max");

    for (int i = 0; i < 8; i++) begin
      rc  = 4'($urandom_range(0, 1));
      ron = 1'($urandom_range(0, 1));
      rn  = 8'($urandom_range(0, 255));
      rv  = 8'($urandom_range(0, 255));
      issue(rc, ron, rn, rv, $sformatf("rnd%0d", i));
      vld = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (rdy !== 1'b0) begin
        check("rnd busy window", 32'(rdy), 32'd0);
      end
      capture_tail_skip(i);
    end

    issue(4'h5, 1'b1, 8'd33, 8'd44, "pre_rst");
    vld = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst tx", 32'(tx), 32'd1);
    check("rst ready", 32'(rdy), 32'd1);
    repeat (3) @(negedge clk);
    check("rst hold tx", 32'(tx), 32'd1);
    check("rst hold busy", 32'(bsy), 32'd0);
    last_vld = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post rst ready", 32'(rdy), 32'd1);
    check("post rst tx", 32'(tx), 32'd1);

    issue(4'h5, 1'b1, 8'd33, 8'd44, "after_rst");
    vld = 1'b0;
    check("after_rst len", 32'(exp_q.size()), 32'd3);
    capture("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Random messages may idle a few cycles before capture;
  // wait out the message and check the line bytes by decode.
  task automatic capture_tail_skip(input int idx);
    int         waited;
    int         nb;
    logic [7:0] dec;
    bit         ok;
    nb = exp_q.size();
    for (int f = 0; f < nb; f++) begin
      ok = 1'b0;
      for (int i = 0; i < 40 * CPB; i++) begin
        if (tx === 1'b0) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check($sformatf("rnd%0d start%0d", idx, f),
            32'(ok), 32'd1);
      repeat (CPB / 2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        dec[b] = tx;
      end
      repeat (CPB) @(negedge clk);
      check($sformatf("rnd%0d byte%0d", idx, f),
            32'(dec), 32'(exp_q[f]));
      check($sformatf("rnd%0d stop%0d", idx, f),
            32'(tx), 32'd1);
      repeat (CPB / 2 - 1) @(negedge clk);
    end
    waited = 0;
    while (rdy !== 1'b1 && waited < 4 * CPB) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("rnd%0d ready", idx),
          32'(rdy), 32'd1);
  endtask

endmodule
